// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: datapath widths, opcodes, flag bit positions
// and small decode helpers.
package exec_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WIDE_W = DATA_W + 1;
  localparam int unsigned MSB    = DATA_W - 1;
  localparam int unsigned REG_AW = 2;
  localparam int unsigned MEM_AW = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 8;
  localparam int unsigned NFLG   = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_NOP   = 4'h0;
  localparam opcode_t OP_ADD   = 4'h1;
  localparam opcode_t OP_SUB   = 4'h2;
  localparam opcode_t OP_AND   = 4'h3;
  localparam opcode_t OP_OR    = 4'h4;
  localparam opcode_t OP_XOR   = 4'h5;
  localparam opcode_t OP_NOT   = 4'h6;
  localparam opcode_t OP_SHL   = 4'h7;
  localparam opcode_t OP_SHR   = 4'h8;
  localparam opcode_t OP_INC   = 4'h9;
  localparam opcode_t OP_DEC   = 4'hA;
  localparam opcode_t OP_MOV   = 4'hB;
  localparam opcode_t OP_LDI   = 4'hC;
  localparam opcode_t OP_LOAD  = 4'hD;
  localparam opcode_t OP_STORE = 4'hE;
  localparam opcode_t OP_CMP   = 4'hF;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_V = 3;

  // NOP, STORE and CMP leave the register file untouched.
  function automatic logic writes_reg(input opcode_t op);
    return !((op == OP_NOP) || (op == OP_STORE) || (op == OP_CMP));
  endfunction

  // NOP and the memory transfers keep the previous flags.
  function automatic logic updates_flags(input opcode_t op);
    return !((op == OP_NOP) || (op == OP_LOAD) || (op == OP_STORE));
  endfunction

endpackage

// File: rtl/exec_if.sv
// Bus between the CPU top (master: instruction and register operands) and the
// execute stage (slave: decoded fields, strobes, result and flags).
interface exec_if;
  import exec_pkg::*;

  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] r0_data;
  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] prevrd;
  logic [DATA_W-1:0] immediate_value;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] flag;

  modport master (
    output inst, reg_a, reg_b, r0_data,
    input  opcode, rd, rs, prevrd, immediate_value, reg_write, mem_read, mem_write,
           mem_access_addr, mem_write_data, alu_result, flag
  );

  modport slave (
    input  inst, reg_a, reg_b, r0_data,
    output opcode, rd, rs, prevrd, immediate_value, reg_write, mem_read, mem_write,
           mem_access_addr, mem_write_data, alu_result, flag
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU: result plus the flag vector this opcode would produce.
// Whether those flags are committed is decided by the caller.
module exec_alu
  import exec_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  opcode_t           opcode,
  output logic [DATA_W-1:0] result,
  output logic [NFLG-1:0]   flags_nxt
);

  logic [WIDE_W-1:0] wide;
  logic              c;
  logic              v;

  always_comb begin
    wide   = '0;
    result = a;
    c      = 1'b0;
    v      = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[MSB:0];
        c      = wide[DATA_W];
        v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      // Bit 8 of the 9-bit difference is the borrow.
      OP_SUB, OP_CMP: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[MSB:0];
        c      = wide[DATA_W];
        v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_INC: begin
        wide   = {1'b0, a} + WIDE_W'(1);
        result = wide[MSB:0];
        c      = wide[DATA_W];
        v      = !a[MSB] && result[MSB];
      end
      OP_DEC: begin
        wide   = {1'b0, a} - WIDE_W'(1);
        result = wide[MSB:0];
        c      = wide[DATA_W];
        v      = a[MSB] && !result[MSB];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        c      = a[MSB];
      end
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        c      = a[0];
      end
      OP_MOV: result = b;
      OP_LDI: result = imm;
      default: result = a;
    endcase

    flags_nxt        = '0;
    flags_nxt[FLG_Z] = (result == '0);
    flags_nxt[FLG_C] = c;
    flags_nxt[FLG_N] = result[MSB];
    flags_nxt[FLG_V] = v;
  end

endmodule

// File: rtl/exec_core.sv
// Execute stage: instruction decode, ALU, load/store strobes and addressing,
// plus the registered status flags and previous destination register.
module exec_core
  import exec_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  exec_if.slave  bus
);

  opcode_t           op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_res;
  logic [NFLG-1:0]   alu_flags;
  logic [FLAG_W-1:0] flag_d, flag_q;
  logic [REG_AW-1:0] prevrd_d, prevrd_q;

  assign op  = opcode_t'(bus.inst[7:4]);
  assign imm = {4'b0000, bus.inst[3:0]};

  exec_alu u_alu (
    .a         (bus.reg_a),
    .b         (bus.reg_b),
    .imm       (imm),
    .opcode    (op),
    .result    (alu_res),
    .flags_nxt (alu_flags)
  );

  assign bus.opcode          = op;
  assign bus.rd              = bus.inst[3:2];
  assign bus.rs              = bus.inst[1:0];
  assign bus.immediate_value = imm;
  assign bus.mem_access_addr = bus.inst[MEM_AW-1:0];
  assign bus.mem_write_data  = bus.r0_data;
  assign bus.alu_result      = alu_res;
  assign bus.flag            = flag_q;
  assign bus.prevrd          = prevrd_q;

  // Strobes are gated by reset so nothing is written while the CPU is held.
  always_comb begin
    bus.reg_write = reset && writes_reg(op);
    bus.mem_read  = reset && (op == OP_LOAD);
    bus.mem_write = reset && (op == OP_STORE);
  end

  always_comb begin
    flag_d   = flag_q;
    prevrd_d = bus.inst[3:2];
    if (updates_flags(op)) begin
      flag_d = FLAG_W'(alu_flags);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q   <= '0;
      prevrd_q <= '0;
    end else begin
      flag_q   <= flag_d;
      prevrd_q <= prevrd_d;
    end
  end

endmodule

// File: tb/tb_exec_core.sv
// Randomised bench for exec_core against an arithmetic reference model of the
// instruction set, with directed boundary cases and a mid-run reset.
module tb_exec_core;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  exec_if bus ();

  exec_core dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  m_flag = 8'h00;
  logic [1:0]  m_prevrd = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Instruction semantics in plain integer arithmetic.
  task automatic ref_model(input int op, input int a, input int b, input int i,
                           output int res, output int c, output int v, output bit upd);
    int t, st;
    res = a; c = 0; v = 0; upd = 1'b1;
    case (op)
      1:      begin t = a + b; st = to_signed8(a) + to_signed8(b); end
      2, 15:  begin t = a - b; st = to_signed8(a) - to_signed8(b); end
      9:      begin t = a + 1; st = to_signed8(a) + 1; end
      10:     begin t = a - 1; st = to_signed8(a) - 1; end
      default: begin t = 0; st = 0; end
    endcase
    case (op)
      1, 2, 9, 10, 15: begin
        res = (t + 256) % 256;
        c   = (t > 255 || t < 0) ? 1 : 0;
        v   = (st > 127 || st < -128) ? 1 : 0;
      end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = 255 - a;
      7:  begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      8:  begin res = a / 2; c = a % 2; end
      11: res = b;
      12: res = i;
      default: begin res = a; upd = 1'b0; end
    endcase
  endtask

  task automatic apply(input logic [7:0] inst, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r0);
    int op, res, c, v;
    bit upd;
    @(negedge clk);
    bus.inst = inst; bus.reg_a = a; bus.reg_b = b; bus.r0_data = r0;
    op = int'(inst[7:4]);
    ref_model(op, int'(a), int'(b), int'(inst[3:0]), res, c, v, upd);
    #1;
    check("alu_result", 32'(bus.alu_result), 32'(res));
    check("reg_write",  32'(bus.reg_write), (op >= 1 && op <= 13) ? 32'd1 : 32'd0);
    check("mem_read",   32'(bus.mem_read),  (op == 13) ? 32'd1 : 32'd0);
    check("mem_write",  32'(bus.mem_write), (op == 14) ? 32'd1 : 32'd0);
    check("mem_addr",   32'(bus.mem_access_addr), 32'(int'(inst) % 16));
    check("mem_wdata",  32'(bus.mem_write_data), 32'(r0));
    check("opcode",     32'(bus.opcode), 32'(op));
    check("rd",         32'(bus.rd), 32'((int'(inst) / 4) % 4));
    check("rs",         32'(bus.rs), 32'(int'(inst) % 4));
    check("imm",        32'(bus.immediate_value), 32'(int'(inst) % 16));
    if (upd)
      m_flag = 8'(((res == 0) ? 1 : 0) + 2 * c + ((res >= 128) ? 4 : 0) + 8 * v);
    m_prevrd = 2'((int'(inst) / 4) % 4);
    @(posedge clk);
    #1;
    check("flag",   32'(bus.flag), 32'(m_flag));
    check("prevrd", 32'(bus.prevrd), 32'(m_prevrd));
  endtask

  task automatic random_run(input int n);
    logic [7:0] a, b;
    logic [7:0] corner [4];
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;
    for (int k = 0; k < n; k++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      apply(8'($urandom), a, b, 8'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.inst = 8'h1D; bus.reg_a = 8'hFF; bus.reg_b = 8'h01; bus.r0_data = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    check("rst_flag",      32'(bus.flag), 32'h00);
    check("rst_prevrd",    32'(bus.prevrd), 32'h0);
    check("rst_reg_write", 32'(bus.reg_write), 32'h0);
    bus.inst = 8'hD9;
    #1 check("rst_mem_read", 32'(bus.mem_read), 32'h0);
    bus.inst = 8'hE3;
    #1 check("rst_mem_write", 32'(bus.mem_write), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.inst = 8'h00;
    rst_n = 1'b1;

    // Directed cases with hand-derived constants.
    apply(8'h1D, 8'hFF, 8'h01, 8'h00);
    check("dir_add_ff_res", 32'(bus.alu_result), 32'h00);
    check("dir_add_ff_flag", 32'(bus.flag), 32'h03);
    apply(8'h26, 8'h05, 8'h07, 8'h00);
    check("dir_sub_res", 32'(bus.alu_result), 32'hFE);
    check("dir_sub_flag", 32'(bus.flag), 32'h06);
    apply(8'hF6, 8'h05, 8'h07, 8'h00);
    check("dir_cmp_rw", 32'(bus.reg_write), 32'h0);
    check("dir_cmp_flag", 32'(bus.flag), 32'h06);
    apply(8'hD9, 8'h12, 8'h34, 8'h00);
    check("dir_load_rd", 32'(bus.mem_read), 32'h1);
    check("dir_load_addr", 32'(bus.mem_access_addr), 32'h9);
    check("dir_load_flag_hold", 32'(bus.flag), 32'h06);
    apply(8'hE3, 8'h00, 8'h00, 8'h5A);
    check("dir_store_wr", 32'(bus.mem_write), 32'h1);
    check("dir_store_data", 32'(bus.mem_write_data), 32'h5A);
    check("dir_store_rw", 32'(bus.reg_write), 32'h0);
    apply(8'h14, 8'h7F, 8'h01, 8'h00);
    check("dir_add_ovf_res", 32'(bus.alu_result), 32'h80);
    check("dir_add_ovf_flag", 32'(bus.flag), 32'h0C);
    apply(8'h70, 8'h81, 8'h00, 8'h00);
    check("dir_shl_res", 32'(bus.alu_result), 32'h02);
    check("dir_shl_flag", 32'(bus.flag), 32'h02);
    apply(8'hA0, 8'h00, 8'h00, 8'h00);
    check("dir_dec_flag", 32'(bus.flag), 32'h06);
    apply(8'h90, 8'hFF, 8'h00, 8'h00);
    check("dir_inc_flag", 32'(bus.flag), 32'h03);
    apply(8'hC7, 8'h55, 8'h00, 8'h00);
    check("dir_ldi_res", 32'(bus.alu_result), 32'h07);

    random_run(300);

    // Reset asserted between clock edges must clear state without a clock.
    apply(8'h1D, 8'hFF, 8'h01, 8'h00);
    @(negedge clk);
    bus.inst = 8'hD9;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_flag",     32'(bus.flag), 32'h00);
    check("mid_rst_prevrd",   32'(bus.prevrd), 32'h0);
    check("mid_rst_reg_write", 32'(bus.reg_write), 32'h0);
    check("mid_rst_mem_read", 32'(bus.mem_read), 32'h0);
    bus.inst = 8'hE3;
    #1 check("mid_rst_mem_write", 32'(bus.mem_write), 32'h0);
    @(posedge clk);
    #1 check("mid_rst_flag_held", 32'(bus.flag), 32'h00);
    @(negedge clk);
    bus.inst = 8'h00;
    rst_n = 1'b1;
    m_flag = 8'h00;
    m_prevrd = 2'b00;

    random_run(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
